// File: rtl/mux_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the 4:1 mux scan controller:
//   - state_e : FSM state encoding (IDLE=0, SCAN=1, DONE=2)
//   - CH_A..CH_D : channel indices as they appear on {s1,s0}
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Bundles the scan request, mux observation and result signals of
// mux_scan_ctrl.
//   start   : scan request (master -> slave)
//   mask    : 4-bit channel enable, bit i = mux input i
//   dwell   : cycles per channel, 0 behaves as 1
//   mux_out : output of the mux being scanned
//   s0, s1  : mux select, channel = {s1,s0}
//   busy    : scan in progress (SCAN and DONE)
//   done    : one-cycle completion pulse
//   samples : captured mux_out per channel
// Modports: master = requester/mux side, slave = controller side.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic               s0;
    logic               s1;
    logic               busy;
    logic               done;
    logic [3:0]         samples;

    modport master (
        output start, mask, dwell, mux_out,
        input  s0, s1, busy, done, samples
    );

    modport slave (
        input  start, mask, dwell, mux_out,
        output s0, s1, busy, done, samples
    );
endinterface

// File: rtl/mux_scan_ctrl_next_ch.sv
// -----------------------------------------------------------------------------
// mux_next_ch
// Purely combinational next-enabled-channel finder.
//   mask  : 4-bit channel enable
//   cur   : current channel index
//   nxt   : lowest set mask bit strictly above cur (cur when none)
//   valid : a higher set bit exists
// -----------------------------------------------------------------------------
module mux_next_ch
    import mux_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    output logic [1:0] nxt,
    output logic       valid
);

    // Scan from the top down so the lowest qualifying bit is the last write.
    always_comb begin
        nxt   = cur;
        valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt   = 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Steps a 4:1 mux through the channels enabled in mask, holding each for
// 'dwell' cycles and (optionally) capturing mux_out on the last dwell cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_scan_ctrl_if.slave (start/mask/dwell/mux_out in,
//           s0/s1/busy/done/samples out)
// Configuration macro: MUX_SCAN_CAPTURE_EN -- when defined, builds the
// samples capture register; otherwise samples reads 4'b0000 and mux_out is
// not observed. Select sequencing and busy/done timing do not depend on it.
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [1:0]         first_above;
    logic               first_above_vld;
    logic [1:0]         first_ch;
    logic               first_vld;
    logic [1:0]         nxt_ch;
    logic               nxt_vld;
    logic               last_dwell;

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // Lowest enabled channel of the incoming mask: channel A itself, or the
    // first set bit above it.
    mux_next_ch u_first (
        .mask  (bus.mask),
        .cur   (CH_A),
        .nxt   (first_above),
        .valid (first_above_vld)
    );
    assign first_ch  = bus.mask[CH_A] ? CH_A : first_above;
    assign first_vld = bus.mask[CH_A] | first_above_vld;

    mux_next_ch u_next (
        .mask  (mask_q),
        .cur   (ch_q),
        .nxt   (nxt_ch),
        .valid (nxt_vld)
    );

    // Counter is loaded with the latched dwell (never 0); <= guards a stray 0.
    assign last_dwell = (cnt_q <= DWELL_W'(1));

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.mask;
                    dwell_d = dwell_eff;
                    if (first_vld) begin
                        ch_d    = first_ch;
                        cnt_d   = dwell_eff;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (last_dwell) begin
                    if (nxt_vld) begin
                        ch_d  = nxt_ch;
                        cnt_d = dwell_q;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= CH_A;
            cnt_q   <= '0;
            mask_q  <= 4'b0000;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.s0   = ch_q[0];
    assign bus.s1   = ch_q[1];
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);

`ifdef MUX_SCAN_CAPTURE_EN
    logic [3:0] samples_q, samples_d;
    logic       cap_en;

    assign cap_en = (state_q == SCAN) && last_dwell;

    always_comb begin
        samples_d = samples_q;
        if (cap_en) begin
            samples_d[ch_q] = bus.mux_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_q <= 4'b0000;
        end else begin
            samples_q <= samples_d;
        end
    end

    assign bus.samples = samples_q;
`else
    assign bus.samples = 4'b0000;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Directed-vector bench for mux_scan_ctrl. The bench models the scanned
// 4:1 mux as mux_in[{s1,s0}]. Expected samples depend on whether
// MUX_SCAN_CAPTURE_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mux_in;

    int n_vec = 0;
    int n_err = 0;

`ifdef MUX_SCAN_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic [1:0] exp35 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.DWELL_W(4)) bus ();

    mux_scan_ctrl #(.DWELL_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mux_out = mux_in[{bus.s1, bus.s0}];

    function automatic logic [3:0] cap(input logic [3:0] v);
        return CAP ? v : 4'b0000;
    endfunction

    function automatic logic [1:0] sel();
        return {bus.s1, bus.s0};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic start_scan(input logic [3:0] m, input logic [3:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = m;
        bus.dwell = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mask  = 4'h0;
        bus.dwell = 4'd0;
        mux_in    = 4'b0101;
        repeat (2) @(negedge clk);
        check("rst_sel", 8'(sel()), 8'd0);
        check("rst_busy", 8'(bus.busy), 8'd0);
        check("rst_done", 8'(bus.done), 8'd0);
        check("rst_samples", 8'(bus.samples), 8'h0);
        rst_n = 1'b1;

        // Full scan, a=1 b=0 c=1 d=0, dwell 2.
        start_scan(4'hF, 4'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c <= 8) begin
                check($sformatf("s35_sel_c%0d", c), 8'(sel()), 8'(exp35[c-1]));
                check($sformatf("s35_busy_c%0d", c), 8'(bus.busy), 8'd1);
                check($sformatf("s35_done_c%0d", c), 8'(bus.done), 8'd0);
            end else if (c == 9) begin
                check("s35_done_c9", 8'(bus.done), 8'd1);
                check("s35_busy_c9", 8'(bus.busy), 8'd1);
                check("s35_sel_c9", 8'(sel()), 8'd3);
                check("s35_samples", 8'(bus.samples), 8'(cap(4'b0101)));
            end else begin
                check("s35_busy_c10", 8'(bus.busy), 8'd0);
                check("s35_done_c10", 8'(bus.done), 8'd0);
                check("s35_sel_c10", 8'(sel()), 8'd3);
            end
        end

        // Sparse mask, dwell 0 behaves as 1; bits 0 and 2 keep old values.
        mux_in = 4'b1010;
        start_scan(4'b1010, 4'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            case (c)
                1: begin
                    check("s36_sel_c1", 8'(sel()), 8'd1);
                    check("s36_busy_c1", 8'(bus.busy), 8'd1);
                end
                2: begin
                    check("s36_sel_c2", 8'(sel()), 8'd3);
                    check("s36_done_c2", 8'(bus.done), 8'd0);
                end
                3: begin
                    check("s36_done_c3", 8'(bus.done), 8'd1);
                    check("s36_samples", 8'(bus.samples), 8'(cap(4'b1111)));
                end
                default: begin
                    check("s36_busy_c4", 8'(bus.busy), 8'd0);
                    check("s36_sel_c4", 8'(sel()), 8'd3);
                end
            endcase
        end

        // Empty mask: straight to DONE, select and samples untouched.
        mux_in = 4'b0000;
        start_scan(4'b0000, 4'd3);
        @(negedge clk);
        bus.start = 1'b0;
        check("s37_done_c1", 8'(bus.done), 8'd1);
        check("s37_busy_c1", 8'(bus.busy), 8'd1);
        check("s37_sel_c1", 8'(sel()), 8'd3);
        check("s37_samples", 8'(bus.samples), 8'(cap(4'b1111)));
        @(negedge clk);
        check("s37_done_c2", 8'(bus.done), 8'd0);
        check("s37_busy_c2", 8'(bus.busy), 8'd0);

        // Start re-pulsed and inputs changed mid-scan, start held into DONE;
        // the start seen in the following IDLE cycle launches a new scan.
        start_scan(4'b0110, 4'd1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("s38_sel_c1", 8'(sel()), 8'd1);
                bus.start = 1'b1;
                bus.mask  = 4'b1001;
                bus.dwell = 4'd5;
            end else if (c == 2) begin
                check("s38_sel_c2", 8'(sel()), 8'd2);
                check("s38_done_c2", 8'(bus.done), 8'd0);
            end else if (c == 3) begin
                check("s38_done_c3", 8'(bus.done), 8'd1);
                check("s38_samples_a", 8'(bus.samples), 8'(cap(4'b1001)));
            end else if (c == 4) begin
                check("s38_busy_c4", 8'(bus.busy), 8'd0);
                check("s38_done_c4", 8'(bus.done), 8'd0);
            end else if (c == 5) begin
                check("s38_sel_c5", 8'(sel()), 8'd0);
                check("s38_busy_c5", 8'(bus.busy), 8'd1);
                bus.start = 1'b0;
            end else if (c == 9) begin
                check("s38_sel_c9", 8'(sel()), 8'd0);
            end else if (c == 10) begin
                check("s38_sel_c10", 8'(sel()), 8'd3);
            end else if (c == 14) begin
                check("s38_done_c14", 8'(bus.done), 8'd0);
            end else if (c == 15) begin
                check("s38_done_c15", 8'(bus.done), 8'd1);
                check("s38_samples_b", 8'(bus.samples), 8'(cap(4'b0000)));
            end else if (c == 16) begin
                check("s38_busy_c16", 8'(bus.busy), 8'd0);
            end
        end

        // Reset in the middle of a scan.
        mux_in = 4'b1111;
        start_scan(4'hF, 4'd3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("s34_sel_pre", 8'(sel()), 8'd1);
        check("s34_samples_pre", 8'(bus.samples), 8'(cap(4'b0001)));
        rst_n = 1'b0;
        #1;
        check("s34_sel_rst", 8'(sel()), 8'd0);
        check("s34_busy_rst", 8'(bus.busy), 8'd0);
        check("s34_done_rst", 8'(bus.done), 8'd0);
        check("s34_samples_rst", 8'(bus.samples), 8'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check($sformatf("s34_done_hold%0d", c), 8'(bus.done), 8'd0);
        end

        // Start accepted on the very first edge after reset release.
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        bus.mask  = 4'b1000;
        bus.dwell = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("s28_sel_c1", 8'(sel()), 8'd3);
        check("s28_busy_c1", 8'(bus.busy), 8'd1);
        @(negedge clk);
        check("s28_done_c2", 8'(bus.done), 8'd1);
        check("s28_samples", 8'(bus.samples), 8'(cap(4'b1000)));
        @(negedge clk);
        check("s28_busy_c3", 8'(bus.busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
